// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle,
// with sign fix-up on magnitudes and N/Z flags registered alongside the result.
module mul_div_unit #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             set_flags,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             update_sreg
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [2:0] OP_MUL   = 3'b000;
  localparam logic [2:0] OP_SMULH = 3'b001;
  localparam logic [2:0] OP_UMULH = 3'b010;
  localparam logic [2:0] OP_UDIV  = 3'b100;
  localparam logic [2:0] OP_SDIV  = 3'b101;

  typedef enum logic [1:0] {IDLE, RUN, FIXUP, DONE} state_t;

  state_t                 state_q, state_d;
  logic [2:0]             op_q, op_d;
  logic                   sf_q, sf_d;
  logic                   neg_q, neg_d;
  logic                   bz_q, bz_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]       m_q, m_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]       result_q, result_d;
  logic                   neg_flag_q, neg_flag_d;
  logic                   zero_flag_q, zero_flag_d;

  logic                   sgn;
  logic [WIDTH-1:0]       amag, bmag;
  logic [WIDTH:0]         rem_sh;
  logic [WIDTH-1:0]       diff;
  logic [WIDTH:0]         sum;
  logic [2*WIDTH-1:0]     prod;
  logic [WIDTH-1:0]       quo;
  logic [WIDTH-1:0]       res;

  function automatic logic legal_op(input logic [2:0] o);
    return (o == OP_MUL) || (o == OP_SMULH) || (o == OP_UMULH) ||
           (o == OP_UDIV) || (o == OP_SDIV);
  endfunction

  // Unsigned ops keep the raw operand; a negated minimum value is exact as unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic signed_op);
    return (signed_op && x[WIDTH-1]) ? -x : x;
  endfunction

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    sf_d        = sf_q;
    neg_d       = neg_q;
    bz_d        = bz_q;
    cnt_d       = cnt_q;
    m_d         = m_q;
    acc_d       = acc_q;
    result_d    = result_q;
    neg_flag_d  = neg_flag_q;
    zero_flag_d = zero_flag_q;
    sgn         = (op == OP_SMULH) || (op == OP_SDIV);
    amag        = mag(a, sgn);
    bmag        = mag(b, sgn);
    rem_sh      = acc_q[2*WIDTH-1:WIDTH-1];
    diff        = rem_sh[WIDTH-1:0] - m_q;
    sum         = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
    prod        = neg_q ? -acc_q : acc_q;
    quo         = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    res         = '0;

    case (state_q)
      IDLE: begin
        if (start && legal_op(op)) begin
          op_d    = op;
          sf_d    = set_flags;
          neg_d   = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
          bz_d    = (b == '0);
          cnt_d   = CW'(WIDTH);
          // Multiply: m holds the multiplicand, acc low half the multiplier.
          // Divide: m holds the divisor, acc low half the dividend.
          m_d     = op[2] ? bmag : amag;
          acc_d   = {{WIDTH{1'b0}}, (op[2] ? amag : bmag)};
          state_d = RUN;
        end
      end
      RUN: begin
        if (op_q[2]) begin
          if (rem_sh >= {1'b0, m_q}) acc_d = {diff, acc_q[WIDTH-2:0], 1'b1};
          else                       acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIXUP;
      end
      FIXUP: begin
        case (op_q)
          OP_SMULH: res = prod[2*WIDTH-1:WIDTH];
          OP_UMULH: res = acc_q[2*WIDTH-1:WIDTH];
          OP_UDIV,
          OP_SDIV:  res = bz_q ? '0 : quo;
          default:  res = prod[WIDTH-1:0];
        endcase
        result_d = res;
        if (sf_q) begin
          neg_flag_d  = res[WIDTH-1];
          zero_flag_d = (res == '0);
        end
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= '0;
      sf_q        <= 1'b0;
      neg_q       <= 1'b0;
      bz_q        <= 1'b0;
      cnt_q       <= '0;
      m_q         <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      neg_flag_q  <= 1'b0;
      zero_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      sf_q        <= sf_d;
      neg_q       <= neg_d;
      bz_q        <= bz_d;
      cnt_q       <= cnt_d;
      m_q         <= m_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      neg_flag_q  <= neg_flag_d;
      zero_flag_q <= zero_flag_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign update_sreg = (state_q == DONE) && sf_q;
  assign result      = result_q;
  assign negative    = neg_flag_q;
  assign zero        = zero_flag_q;
  assign carry       = 1'b0;
  assign overflow    = 1'b0;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed vector table, multi-cycle corner sequences,
// and random operations checked against a wide-arithmetic reference model.
module tb_mul_div_unit;
  localparam int W = 64;
  localparam logic [2:0] OP_MUL = 3'b000, OP_SMULH = 3'b001, OP_UMULH = 3'b010,
                         OP_UDIV = 3'b100, OP_SDIV = 3'b101;

  logic         clk, reset, start, set_flags;
  logic [2:0]   op;
  logic [W-1:0] a, b, result;
  logic         busy, done, negative, zero, carry, overflow, update_sreg;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .set_flags(set_flags), .busy(busy), .done(done), .result(result),
    .negative(negative), .zero(zero), .carry(carry), .overflow(overflow),
    .update_sreg(update_sreg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_n = 1'b0;
  logic exp_z = 1'b0;

  typedef struct {
    string        name;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sf;
    logic [W-1:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: exact 128-bit products and quotients, then take the required slice.
  function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [2*W-1:0] sx, sy, sp, sq;
    logic [2*W-1:0]        up;
    sx = {{W{x[W-1]}}, x};
    sy = {{W{y[W-1]}}, y};
    sp = sx * sy;
    up = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    case (o)
      OP_MUL:   return up[W-1:0];
      OP_SMULH: return sp[2*W-1:W];
      OP_UMULH: return up[2*W-1:W];
      OP_UDIV:  return (y == 0) ? '0 : x / y;
      default: begin
        if (y == 0) return '0;
        sq = sx / sy;
        return sq[W-1:0];
      end
    endcase
  endfunction

  task automatic run_op(input string nm, input logic [2:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic sf, input logic [W-1:0] ex,
                        input int poke);
    int   n;
    logic busy_ok;
    @(negedge clk);
    op = o; a = x; b = y; set_flags = sf; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = ~x; b = ~y; op = OP_MUL; set_flags = ~sf;
    check({nm, " busy_after_accept"}, busy, 1'b1);
    n = 0;
    busy_ok = 1'b1;
    while (!done && n < 3 * W) begin
      if (n == poke) begin
        start = 1'b1; op = OP_UDIV; a = 64'd5; b = 64'd1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      n++;
      if (!busy) busy_ok = 1'b0;
    end
    check({nm, " latency"}, n, W + 1);
    check({nm, " busy_held"}, busy_ok, 1'b1);
    if (sf) begin
      exp_n = ex[W-1];
      exp_z = (ex == '0);
    end
    check({nm, " result"}, result, ex);
    check({nm, " update_sreg"}, update_sreg, sf);
    check({nm, " N"}, negative, exp_n);
    check({nm, " Z"}, zero, exp_z);
    check({nm, " C_V"}, {carry, overflow}, 2'b00);
    @(posedge clk); #1;
    check({nm, " idle_after_done"}, {busy, done, update_sreg}, 3'b000);
    check({nm, " result_held"}, result, ex);
  endtask

  vec_t vecs[$];

  initial begin
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; set_flags = 1'b0;

    vecs.push_back('{"umulh_max_x2", OP_UMULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1, 64'd1});
    vecs.push_back('{"mul_m3_5",     OP_MUL,   -64'sd3, 64'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1});
    vecs.push_back('{"smulh_m3_5",   OP_SMULH, -64'sd3, 64'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
    vecs.push_back('{"sdiv_m7_2",    OP_SDIV,  -64'sd7, 64'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD});
    vecs.push_back('{"udiv_by_zero", OP_UDIV,  64'd100, 64'd0, 1'b1, 64'd0});
    vecs.push_back('{"sdiv_min_m1",  OP_SDIV,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                     64'h8000_0000_0000_0000});
    vecs.push_back('{"mul_6_7",      OP_MUL,   64'd6, 64'd7, 1'b1, 64'd42});
    vecs.push_back('{"udiv_100_7",   OP_UDIV,  64'd100, 64'd7, 1'b0, 64'd14});
    vecs.push_back('{"sdiv_7_m2",    OP_SDIV,  64'd7, -64'sd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD});
    vecs.push_back('{"smulh_min_min", OP_SMULH, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1,
                     64'h4000_0000_0000_0000});
    vecs.push_back('{"umulh_max_max", OP_UMULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                     64'hFFFF_FFFF_FFFF_FFFE});
    vecs.push_back('{"sdiv_by_zero", OP_SDIV,  -64'sd9, 64'd0, 1'b1, 64'd0});

    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {busy, done, update_sreg, negative, zero, carry, overflow}, 7'b0);
    check("reset_result", result, '0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sf, vecs[i].exp, -1);

    // Illegal opcodes must not start the unit.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      op = (k == 0) ? 3'b011 : (k == 1) ? 3'b110 : 3'b111;
      start = 1'b1; a = 64'd3; b = 64'd3;
      @(posedge clk); #1;
      start = 1'b0;
      check("illegal_op_ignored", {busy, done}, 2'b00);
    end

    // A second start mid-run is dropped; the original division completes.
    run_op("udiv_restart_ignored", OP_UDIV, 64'd1000, 64'd10, 1'b1, 64'd100, 10);

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    op = OP_MUL; a = 64'd123; b = 64'd456; set_flags = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (29) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("midrun_reset_ctrl", {busy, done, update_sreg, negative, zero}, 5'b0);
    check("midrun_reset_result", result, '0);
    @(negedge clk);
    reset = 1'b0;
    exp_n = 1'b0;
    exp_z = 1'b0;
    run_op("mul_after_reset", OP_MUL, 64'd6, 64'd7, 1'b1, 64'd42, -1);

    // Random operations against the reference model.
    for (int r = 0; r < 40; r++) begin
      logic [2:0]   ro;
      logic [W-1:0] ra, rb;
      logic         rsf;
      case ($urandom_range(0, 4))
        0: ro = OP_MUL;
        1: ro = OP_SMULH;
        2: ro = OP_UMULH;
        3: ro = OP_UDIV;
        default: ro = OP_SDIV;
      endcase
      ra = {$urandom(), $urandom()};
      case ($urandom_range(0, 3))
        0: rb = W'($urandom_range(0, 20));
        1: rb = -W'($urandom_range(1, 20));
        2: rb = W'($urandom());
        default: rb = {$urandom(), $urandom()};
      endcase
      if ($urandom_range(0, 3) == 0) ra = W'($urandom_range(0, 1000));
      rsf = 1'($urandom_range(0, 1));
      run_op("random", ro, ra, rb, rsf, model(ro, ra, rb), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
